// File: rtl/lpm_divide_seq.sv
// Sequential unsigned restoring divider: one quotient bit per enabled clock,
// quotient/remainder returned with a one-cycle done pulse.
module lpm_divide_seq #(
  parameter int lpm_widthn = 8,
  parameter int lpm_widthd = 4
) (
  input  logic                  clock,
  input  logic                  aclr_n,
  input  logic                  clken,
  input  logic                  start,
  input  logic [lpm_widthn-1:0] numer,
  input  logic [lpm_widthd-1:0] denom,
  output logic                  busy,
  output logic                  done,
  output logic [lpm_widthn-1:0] quotient,
  output logic [lpm_widthd-1:0] remain,
  output logic                  div_by_zero
);

  localparam int unsigned CW = $clog2(lpm_widthn + 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t                state, state_next;
  logic [lpm_widthd-1:0] r, d, r_next, t_lo;
  logic                  t_hi, t_ge, last;
  logic [lpm_widthn-1:0] q, q_next;
  logic [CW-1:0]         cnt;

  // State register
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n)    state <= IDLE;
    else if (clken) state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && denom != '0) state_next = CALC;
      CALC: if (last)                 state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state == CALC);
  end

  // The partial remainder stays below the divisor, so only the shifted-in
  // top bit can exceed lpm_widthd bits; the modular subtract absorbs it.
  always_comb begin
    {t_hi, t_lo} = {r, q[lpm_widthn-1]};
    t_ge   = t_hi || (t_lo >= d);
    r_next = t_ge ? (t_lo - d) : t_lo;
    q_next = (q << 1) | lpm_widthn'(t_ge);
    last   = (cnt == CW'(1));
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r           <= '0;
      d           <= '0;
      q           <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remain      <= '0;
      div_by_zero <= 1'b0;
    end else if (clken) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (denom != '0) begin
              r           <= '0;
              d           <= denom;
              q           <= numer;
              cnt         <= CW'(lpm_widthn);
              div_by_zero <= 1'b0;
            end else begin
              quotient    <= '1;
              remain      <= lpm_widthd'(numer);
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end
          end
        end
        CALC: begin
          r   <= r_next;
          q   <= q_next;
          cnt <= cnt - CW'(1);
          if (last) begin
            quotient <= q_next;
            remain   <= r_next;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lpm_divide_seq.sv
// Scoreboard bench for lpm_divide_seq: the driver queues expected results,
// a negedge monitor checks each done pulse against the queue.
module tb_lpm_divide_seq;

  logic       clock, aclr_n, clken, start;
  logic [7:0] numer;
  logic [3:0] denom;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remain;

  lpm_divide_seq #(.lpm_widthn(8), .lpm_widthd(4)) dut (
    .clock(clock), .aclr_n(aclr_n), .clken(clken), .start(start),
    .numer(numer), .denom(denom), .busy(busy), .done(done),
    .quotient(quotient), .remain(remain), .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [7:0]  q;
    logic [3:0]  r;
    logic        z;
    int unsigned at_edge;
  } exp_t;

  exp_t        sb[$];
  int unsigned vectors = 0, miscompares = 0;
  int unsigned en_edges = 0, cycles = 0;
  logic        edge_en = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    cycles++;
    edge_en = clken && aclr_n;
    if (clken && aclr_n) en_edges++;
  end

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: a done counts once per enabled edge that produced it
  always @(negedge clock) begin
    if (aclr_n && done && edge_en) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remain", remain, e.r);
        check("div_by_zero", div_by_zero, e.z);
        check("latency_edge", en_edges, e.at_edge);
      end
    end
  end

  // Called #1 after an enabled edge; the next edge accepts the request.
  task automatic issue(input logic [7:0] n, input logic [3:0] d,
                       input logic [7:0] eq, input logic [3:0] er, input logic ez);
    exp_t e;
    e.q = eq; e.r = er; e.z = ez;
    e.at_edge = en_edges + 1 + (ez ? 0 : 8);
    sb.push_back(e);
    numer = n; denom = d; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 40; k++) begin
      if (done) return;
      @(posedge clock); #1;
    end
    check("done_timeout", 0, 1);
  endtask

  initial begin
    int unsigned c0;
    aclr_n = 1'b0; clken = 1'b1; start = 1'b0; numer = '0; denom = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remain", remain, 0);
    check("rst_dbz", div_by_zero, 0);
    @(posedge clock); #1; aclr_n = 1'b1;
    @(posedge clock); #1;

    // 200 / 7: busy for 8 cycles then 28 r4
    issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("busy_calc", busy, 1);
      @(posedge clock); #1;
    end
    check("busy_after", busy, 0);
    check("done_at_latency", done, 1);

    // back-to-back: 255/1 then 5/9 issued in the done cycle
    @(posedge clock); #1;
    issue(8'd255, 4'd1, 8'd255, 4'd0, 1'b0);
    wait_done();
    issue(8'd5, 4'd9, 8'd0, 4'd5, 1'b0);
    wait_done();
    @(posedge clock); #1;

    // divide by zero: immediate result, no busy
    issue(8'd100, 4'd0, 8'd255, 4'd4, 1'b1);
    check("dbz_busy", busy, 0);
    check("dbz_done", done, 1);
    @(posedge clock); #1;
    check("dbz_busy_later", busy, 0);
    check("dbz_done_cleared", done, 0);

    // clken low for 3 cycles mid-calc, plus an ignored start during busy
    c0 = cycles + 1;
    issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
    @(posedge clock); #1;
    numer = 8'd1; denom = 4'd1; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    clken = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    clken = 1'b1;
    wait_done();
    check("clken_latency", cycles - c0, 11);
    // done stretched while clken is low
    clken = 1'b0;
    @(posedge clock); #1;
    check("done_stretch", done, 1);
    clken = 1'b1;
    @(posedge clock); #1;
    check("done_clear", done, 0);

    // asynchronous reset during CALC aborts without done
    issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
    repeat (3) begin @(posedge clock); #1; end
    aclr_n = 1'b0;
    #1;
    sb.delete();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remain", remain, 0);
    check("abort_dbz", div_by_zero, 0);
    @(posedge clock); #1; aclr_n = 1'b1;
    repeat (12) begin @(posedge clock); #1; end
    check("abort_no_done", done, 0);
    issue(8'd15, 4'd4, 8'd3, 4'd3, 1'b0);
    wait_done();
    @(posedge clock); #1;

    // sweep of operand pairs, issued back-to-back on each done
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] n;
      logic [3:0] d;
      n = 8'($urandom_range(0, 255));
      d = 4'($urandom_range(1, 15));
      issue(n, d, n / d, 4'(n % d), 1'b0);
      wait_done();
    end

    repeat (3) begin @(posedge clock); #1; end
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
